// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, IF/ID pipeline register, redirect/stall flush and HALT freeze.
// Optional single-step port enabled by `define PC_FETCH_STEP_EN.
module pc_fetch_unit #(
   parameter int unsigned      NBITS       = 32,
   parameter logic [NBITS-1:0] RESET_PC    = '0,
   parameter logic [NBITS-1:0] HALT_OPCODE = '1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_Enable,
`ifdef PC_FETCH_STEP_EN
   input  logic             i_Step,
`endif
   input  logic             i_Stall,
   input  logic             i_Redirect,
   input  logic [NBITS-1:0] i_RedirectPC,
   input  logic [NBITS-1:0] i_Instr,
   output logic [NBITS-1:0] o_PC,
   output logic [NBITS-1:0] o_PCPlus4,
   output logic [NBITS-1:0] o_IF_Instr,
   output logic [NBITS-1:0] o_IF_PCPlus4,
   output logic             o_IF_Valid,
   output logic             o_Halted
);

   localparam logic StRun    = 1'b0;
   localparam logic StHalted = 1'b1;

   logic             state_q, state_d;
   logic [NBITS-1:0] pc_q, pc_d;
   logic [NBITS-1:0] if_instr_q, if_instr_d;
   logic [NBITS-1:0] if_pcplus4_q, if_pcplus4_d;
   logic             if_valid_q, if_valid_d;
   logic [NBITS-1:0] pc_plus4;
   logic             go, active, do_redirect, do_advance, halt_hit;

   // Target low bits are dropped; PC stays word aligned.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^i_RedirectPC[1:0];

   assign pc_plus4 = pc_q + NBITS'(4);

`ifdef PC_FETCH_STEP_EN
   assign go = i_Enable | i_Step;
`else
   assign go = i_Enable;
`endif

   assign active      = go && (state_q == StRun);
   assign do_redirect = active && i_Redirect;
   assign do_advance  = active && !i_Redirect && !i_Stall;
   assign halt_hit    = do_advance && (i_Instr == HALT_OPCODE);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      if_instr_d   = if_instr_q;
      if_pcplus4_d = if_pcplus4_q;
      if_valid_d   = if_valid_q;
      if (do_redirect) begin
         pc_d         = {i_RedirectPC[NBITS-1:2], 2'b00};
         if_instr_d   = '0;
         if_pcplus4_d = '0;
         if_valid_d   = 1'b0;
      end else if (do_advance) begin
         if_instr_d   = i_Instr;
         if_pcplus4_d = pc_plus4;
         if_valid_d   = 1'b1;
         // HALT is latched into IF/ID but the PC parks on it.
         if (halt_hit) begin
            state_d = StHalted;
         end else begin
            pc_d = pc_plus4;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= StRun;
         pc_q         <= RESET_PC;
         if_instr_q   <= '0;
         if_pcplus4_q <= '0;
         if_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         if_instr_q   <= if_instr_d;
         if_pcplus4_q <= if_pcplus4_d;
         if_valid_q   <= if_valid_d;
      end
   end

   assign o_PC         = pc_q;
   assign o_PCPlus4    = pc_plus4;
   assign o_IF_Instr   = if_instr_q;
   assign o_IF_PCPlus4 = if_pcplus4_q;
   assign o_IF_Valid   = if_valid_q;
   assign o_Halted     = (state_q == StHalted);

endmodule
